// File: rtl/perf_counter_source.sv
// Performance-counter producer: saturating event counters gated by a
// run-control FSM (IDLE/RUN/DRAIN/DONE), exported as a packed counter bus.

module perf_sat_counter #(
  parameter int W  = 64,
  parameter int IW = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic [IW-1:0] inc,
  output logic [W-1:0]  count
);
  logic [W:0] sum;

  // One extra carry bit detects overflow; clamp to all-ones instead of wrapping.
  assign sum = {1'b0, count} + (W+1)'(inc);

  always_ff @(posedge clock) begin
    if (!reset_n || clr) count <= '0;
    else if (en)         count <= sum[W] ? {W{1'b1}} : sum[W-1:0];
  end
endmodule

module perf_warp_lane #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic         decode,
  input  logic         waw,
  input  logic         war,
  input  logic         busy,
  output logic [W-1:0] dec_cnt,
  output logic [W-1:0] waw_cnt,
  output logic [W-1:0] war_cnt,
  output logic [W-1:0] busy_cnt
);
  logic waw_hit, war_hit, busy_hit;

  // A stall is only attributed to a warp holding a decoded instruction,
  // and only to its highest-priority cause.
  assign waw_hit  = decode & waw;
  assign war_hit  = decode & ~waw & war;
  assign busy_hit = decode & ~waw & ~war & busy;

  perf_sat_counter #(.W(W), .IW(1)) u_dec (
    .clock(clock), .reset_n(reset_n), .clr(clr), .en(en), .inc(decode), .count(dec_cnt));
  perf_sat_counter #(.W(W), .IW(1)) u_waw (
    .clock(clock), .reset_n(reset_n), .clr(clr), .en(en), .inc(waw_hit), .count(waw_cnt));
  perf_sat_counter #(.W(W), .IW(1)) u_war (
    .clock(clock), .reset_n(reset_n), .clr(clr), .en(en), .inc(war_hit), .count(war_cnt));
  perf_sat_counter #(.W(W), .IW(1)) u_busy (
    .clock(clock), .reset_n(reset_n), .clr(clr), .en(en), .inc(busy_hit), .count(busy_cnt));
endmodule

module perf_counter_source #(
  parameter int NUM_WARPS     = 8,
  parameter int COUNTER_WIDTH = 64,
  parameter int RETIRE_WIDTH  = 2,
  parameter int DRAIN_CYCLES  = 16
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               clear,
  input  logic                               all_warps_done,
  input  logic [RETIRE_WIDTH-1:0]            retire_count,
  input  logic [NUM_WARPS-1:0]               decode_valid,
  input  logic                               eligible,
  input  logic                               issued,
  input  logic [NUM_WARPS-1:0]               stall_waw,
  input  logic [NUM_WARPS-1:0]               stall_war,
  input  logic [NUM_WARPS-1:0]               stall_busy,
  output logic                               finished,
  output logic [COUNTER_WIDTH-1:0]           instRetired,
  output logic [COUNTER_WIDTH-1:0]           cycles,
  output logic [COUNTER_WIDTH-1:0]           cyclesDecoded,
  output logic [COUNTER_WIDTH-1:0]           cyclesEligible,
  output logic [COUNTER_WIDTH-1:0]           cyclesIssued,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_cyclesDecoded,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_stallsWAW,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_stallsWAR,
  output logic [NUM_WARPS*COUNTER_WIDTH-1:0] perWarp_stallsBusy
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_d;
  logic [DW-1:0] drain_cnt, drain_d;
  logic          count_en;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      finished  <= 1'b0;
    end else begin
      state     <= state_d;
      drain_cnt <= drain_d;
      finished  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state;
    drain_d = drain_cnt;
    unique case (state)
      IDLE: if (start) state_d = RUN;
      RUN: if (all_warps_done) begin
        if (DRAIN_CYCLES == 0) state_d = DONE;
        else begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        drain_d = drain_cnt - DW'(1);
        if (drain_cnt == DW'(1)) state_d = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    // clear outranks every other control input
    if (clear) begin
      state_d = IDLE;
      drain_d = '0;
    end
  end

  assign count_en = (state == RUN) || (state == DRAIN);

  perf_sat_counter #(.W(COUNTER_WIDTH), .IW(1)) u_cycles (
    .clock(clock), .reset_n(reset_n), .clr(clear), .en(count_en),
    .inc(1'b1), .count(cycles));
  perf_sat_counter #(.W(COUNTER_WIDTH), .IW(RETIRE_WIDTH)) u_retired (
    .clock(clock), .reset_n(reset_n), .clr(clear), .en(count_en),
    .inc(retire_count), .count(instRetired));
  perf_sat_counter #(.W(COUNTER_WIDTH), .IW(1)) u_decoded (
    .clock(clock), .reset_n(reset_n), .clr(clear), .en(count_en),
    .inc(|decode_valid), .count(cyclesDecoded));
  perf_sat_counter #(.W(COUNTER_WIDTH), .IW(1)) u_eligible (
    .clock(clock), .reset_n(reset_n), .clr(clear), .en(count_en),
    .inc(eligible), .count(cyclesEligible));
  perf_sat_counter #(.W(COUNTER_WIDTH), .IW(1)) u_issued (
    .clock(clock), .reset_n(reset_n), .clr(clear), .en(count_en),
    .inc(issued), .count(cyclesIssued));

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_lane
    perf_warp_lane #(.W(COUNTER_WIDTH)) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (clear),
      .en      (count_en),
      .decode  (decode_valid[w]),
      .waw     (stall_waw[w]),
      .war     (stall_war[w]),
      .busy    (stall_busy[w]),
      .dec_cnt (perWarp_cyclesDecoded[w*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .waw_cnt (perWarp_stallsWAW[w*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .war_cnt (perWarp_stallsWAR[w*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .busy_cnt(perWarp_stallsBusy[w*COUNTER_WIDTH +: COUNTER_WIDTH])
    );
  end
endmodule

// File: tb/tb_perf_counter_source.sv
// Bench for perf_counter_source: directed scenarios plus randomized traffic
// compared against a time-window reference model (wide and 8-bit instances).
module tb_perf_counter_source;
  localparam int NW = 8, CW = 64, RW = 2, DC = 16, NCW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n, start, clear, all_warps_done, eligible, issued;
  logic [RW-1:0] retire_count;
  logic [NW-1:0] decode_valid, stall_waw, stall_war, stall_busy;

  logic          finished, n_finished;
  logic [CW-1:0] instRetired, cycles, cyclesDecoded, cyclesEligible, cyclesIssued;
  logic [NW*CW-1:0] pw_dec, pw_waw, pw_war, pw_busy;
  logic [NCW-1:0] n_ret, n_cyc, n_dec, n_elig, n_iss;
  logic [NW*NCW-1:0] n_pwdec, n_pwwaw, n_pwwar, n_pwbusy;

  perf_counter_source #(.NUM_WARPS(NW), .COUNTER_WIDTH(CW), .RETIRE_WIDTH(RW), .DRAIN_CYCLES(DC)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .clear(clear),
    .all_warps_done(all_warps_done), .retire_count(retire_count), .decode_valid(decode_valid),
    .eligible(eligible), .issued(issued), .stall_waw(stall_waw), .stall_war(stall_war),
    .stall_busy(stall_busy), .finished(finished), .instRetired(instRetired), .cycles(cycles),
    .cyclesDecoded(cyclesDecoded), .cyclesEligible(cyclesEligible), .cyclesIssued(cyclesIssued),
    .perWarp_cyclesDecoded(pw_dec), .perWarp_stallsWAW(pw_waw), .perWarp_stallsWAR(pw_war),
    .perWarp_stallsBusy(pw_busy));

  perf_counter_source #(.NUM_WARPS(NW), .COUNTER_WIDTH(NCW), .RETIRE_WIDTH(RW), .DRAIN_CYCLES(DC)) dut_n (
    .clock(clock), .reset_n(reset_n), .start(start), .clear(clear),
    .all_warps_done(all_warps_done), .retire_count(retire_count), .decode_valid(decode_valid),
    .eligible(eligible), .issued(issued), .stall_waw(stall_waw), .stall_war(stall_war),
    .stall_busy(stall_busy), .finished(n_finished), .instRetired(n_ret), .cycles(n_cyc),
    .cyclesDecoded(n_dec), .cyclesEligible(n_elig), .cyclesIssued(n_iss),
    .perWarp_cyclesDecoded(n_pwdec), .perWarp_stallsWAW(n_pwwaw), .perWarp_stallsWAR(n_pwwar),
    .perWarp_stallsBusy(n_pwbusy));

  int checks = 0, errors = 0;

  // Reference model: a measurement window opens on start and closes DC edges
  // after the edge that saw all_warps_done; events are counted on every edge
  // inside the window. Counts are kept exact; saturation is applied at compare.
  bit     m_open, m_fin;
  longint m_end, m_edge;
  longint m_cyc, m_ret, m_dec, m_elig, m_iss;
  longint m_pwdec[NW], m_waw[NW], m_war[NW], m_busy[NW];

  function automatic logic [NCW-1:0] nsat(longint v);
    return (v > 255) ? 8'hFF : NCW'(v);
  endfunction

  task automatic model_step();
    bit cnt;
    if (!reset_n || clear) begin
      m_open = 0; m_end = -1;
      m_cyc = 0; m_ret = 0; m_dec = 0; m_elig = 0; m_iss = 0;
      for (int w = 0; w < NW; w++) begin m_pwdec[w] = 0; m_waw[w] = 0; m_war[w] = 0; m_busy[w] = 0; end
    end else begin
      cnt = m_open && (m_end < 0 || m_edge <= m_end);
      if (cnt) begin
        m_cyc++;
        m_ret += longint'(retire_count);
        if (decode_valid != 0) m_dec++;
        m_elig += longint'(eligible);
        m_iss  += longint'(issued);
        for (int w = 0; w < NW; w++) if (decode_valid[w]) begin
          m_pwdec[w]++;
          if (stall_waw[w]) m_waw[w]++;
          else if (stall_war[w]) m_war[w]++;
          else if (stall_busy[w]) m_busy[w]++;
        end
      end
      if (!m_open && start) m_open = 1;
      else if (m_open && m_end < 0 && all_warps_done) m_end = m_edge + DC;
    end
    m_fin = m_open && (m_end >= 0) && (m_edge >= m_end);
    m_edge++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    start = 0; clear = 0; all_warps_done = 0; eligible = 0; issued = 0;
    retire_count = '0; decode_valid = '0; stall_waw = '0; stall_war = '0; stall_busy = '0;
  endtask

  task automatic test_reset();
    idle_inputs(); reset_n = 0; start = 1; tick(); tick();
    checks++; if (cycles !== 64'd0) begin errors++; $display("FAIL reset_cycles got %0d want 0", cycles); end
    checks++; if (instRetired !== 64'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", instRetired); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished got %b want 0", finished); end
    checks++; if (pw_busy !== '0) begin errors++; $display("FAIL reset_pw_busy got %h want 0", pw_busy); end
    checks++; if (n_cyc !== 8'd0) begin errors++; $display("FAIL reset_narrow_cycles got %0d want 0", n_cyc); end
    reset_n = 1; start = 0;
  endtask

  task automatic test_basic_window();
    reset_n = 0; tick(); reset_n = 1;
    repeat (4) tick();
    start = 1; tick(); start = 0;
    repeat (19) tick();
    all_warps_done = 1; tick(); all_warps_done = 0;
    repeat (15) tick();
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL window_early_finished got %b want 0", finished); end
    tick();
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL window_finished_rise got %b want 1", finished); end
    checks++; if (cycles !== 64'd36) begin errors++; $display("FAIL window_cycles got %0d want 36", cycles); end
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom); all_warps_done = 1'($urandom); tick();
      checks++; if (finished !== 1'b1 || cycles !== 64'd36) begin
        errors++; $display("FAIL window_hold step %0d got fin=%b cycles=%0d want 1/36", i, finished, cycles);
      end
    end
    idle_inputs();
  endtask

  task automatic test_retire_decode();
    clear = 1; tick(); clear = 0;
    start = 1; tick(); start = 0;
    retire_count = 2'd3; decode_valid = 8'h05; issued = 1;
    repeat (10) tick();
    idle_inputs();
    checks++; if (instRetired !== 64'd30) begin errors++; $display("FAIL rd_retired got %0d want 30", instRetired); end
    checks++; if (cyclesDecoded !== 64'd10) begin errors++; $display("FAIL rd_decoded got %0d want 10", cyclesDecoded); end
    checks++; if (cyclesIssued !== 64'd10) begin errors++; $display("FAIL rd_issued got %0d want 10", cyclesIssued); end
    checks++; if (cyclesEligible !== 64'd0) begin errors++; $display("FAIL rd_eligible got %0d want 0", cyclesEligible); end
    for (int w = 0; w < NW; w++) begin
      checks++;
      if (pw_dec[w*CW +: CW] !== ((w == 0 || w == 2) ? 64'd10 : 64'd0)) begin
        errors++; $display("FAIL rd_pw_dec warp %0d got %0d want %0d", w, pw_dec[w*CW +: CW], (w == 0 || w == 2) ? 10 : 0);
      end
    end
  endtask

  task automatic test_stall_priority();
    logic [3:0] pat [8];  // {decode, waw, war, busy} for warp 3
    pat = '{4'b1111, 4'b1111, 4'b1011, 4'b1011, 4'b1001, 4'b1000, 4'b0111, 4'b0011};
    clear = 1; tick(); clear = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 8; i++) begin
      decode_valid = NW'(pat[i][3]) << 3;
      stall_waw    = NW'(pat[i][2]) << 3;
      stall_war    = NW'(pat[i][1]) << 3;
      stall_busy   = NW'(pat[i][0]) << 3;
      tick();
    end
    idle_inputs();
    checks++; if (pw_waw[3*CW +: CW] !== 64'd2) begin errors++; $display("FAIL stall_waw got %0d want 2", pw_waw[3*CW +: CW]); end
    checks++; if (pw_war[3*CW +: CW] !== 64'd2) begin errors++; $display("FAIL stall_war got %0d want 2", pw_war[3*CW +: CW]); end
    checks++; if (pw_busy[3*CW +: CW] !== 64'd1) begin errors++; $display("FAIL stall_busy got %0d want 1", pw_busy[3*CW +: CW]); end
    checks++; if (pw_dec[3*CW +: CW] !== 64'd6) begin errors++; $display("FAIL stall_dec got %0d want 6", pw_dec[3*CW +: CW]); end
    checks++; if (pw_waw[2*CW +: CW] !== 64'd0) begin errors++; $display("FAIL stall_other_warp got %0d want 0", pw_waw[2*CW +: CW]); end
  endtask

  task automatic test_saturation();
    clear = 1; tick(); clear = 0;
    start = 1; tick(); start = 0;
    retire_count = 2'd3; repeat (84) tick();
    retire_count = 2'd2; tick();
    checks++; if (n_ret !== 8'd254) begin errors++; $display("FAIL sat_ret_254 got %0d want 254", n_ret); end
    retire_count = 2'd3; tick();
    checks++; if (n_ret !== 8'd255) begin errors++; $display("FAIL sat_ret_clamp got %0d want 255", n_ret); end
    checks++; if (instRetired !== 64'd257) begin errors++; $display("FAIL sat_wide_ret got %0d want 257", instRetired); end
    retire_count = 2'd0; repeat (214) tick();
    checks++; if (n_cyc !== 8'd255) begin errors++; $display("FAIL sat_cycles got %0d want 255", n_cyc); end
    checks++; if (cycles !== 64'd300) begin errors++; $display("FAIL sat_wide_cycles got %0d want 300", cycles); end
    checks++; if (n_ret !== 8'd255) begin errors++; $display("FAIL sat_ret_hold got %0d want 255", n_ret); end
  endtask

  task automatic test_clear_precedence();
    all_warps_done = 1; tick(); all_warps_done = 0;
    repeat (16) tick();
    checks++; if (finished !== 1'b1 || n_finished !== 1'b1) begin errors++; $display("FAIL clr_done got %b/%b want 1/1", finished, n_finished); end
    clear = 1; start = 1; tick(); clear = 0; start = 0;
    checks++; if (cycles !== 64'd0 || n_cyc !== 8'd0) begin errors++; $display("FAIL clr_cycles got %0d/%0d want 0", cycles, n_cyc); end
    checks++; if (instRetired !== 64'd0) begin errors++; $display("FAIL clr_retired got %0d want 0", instRetired); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL clr_finished got %b want 0", finished); end
    repeat (3) tick();
    checks++; if (cycles !== 64'd0) begin errors++; $display("FAIL clr_idle got %0d want 0", cycles); end
    start = 1; tick(); start = 0; tick();
    checks++; if (cycles !== 64'd1) begin errors++; $display("FAIL clr_fresh_window got %0d want 1", cycles); end
  endtask

  task automatic test_reset_mid_drain();
    clear = 1; tick(); clear = 0;
    start = 1; tick(); start = 0;
    repeat (5) tick();
    all_warps_done = 1; tick(); all_warps_done = 0;
    repeat (5) tick();
    reset_n = 0; start = 1; all_warps_done = 1; tick();
    reset_n = 1; start = 0; all_warps_done = 0;
    checks++; if (cycles !== 64'd0 || finished !== 1'b0) begin errors++; $display("FAIL rst_drain got cycles=%0d fin=%b want 0/0", cycles, finished); end
    for (int i = 0; i < 20; i++) begin all_warps_done = i[0]; tick(); end
    all_warps_done = 0;
    checks++; if (cycles !== 64'd0 || finished !== 1'b0) begin errors++; $display("FAIL rst_awd_ignored got cycles=%0d fin=%b want 0/0", cycles, finished); end
    start = 1; tick(); start = 0; tick(); tick();
    checks++; if (cycles !== 64'd2) begin errors++; $display("FAIL rst_restart got %0d want 2", cycles); end
  endtask

  task automatic test_random();
    clear = 1; tick(); clear = 0;
    for (int i = 0; i < 400; i++) begin
      reset_n        = ($urandom_range(0, 79) != 0);
      clear          = ($urandom_range(0, 59) == 0);
      start          = ($urandom_range(0, 7) == 0);
      all_warps_done = ($urandom_range(0, 19) == 0);
      retire_count   = RW'($urandom);
      decode_valid   = NW'($urandom);
      stall_waw      = NW'($urandom);
      stall_war      = NW'($urandom);
      stall_busy     = NW'($urandom);
      eligible       = 1'($urandom);
      issued         = 1'($urandom);
      tick();
      checks++;
      if (cycles !== 64'(m_cyc) || instRetired !== 64'(m_ret) || cyclesDecoded !== 64'(m_dec) ||
          cyclesEligible !== 64'(m_elig) || cyclesIssued !== 64'(m_iss) || finished !== m_fin) begin
        errors++;
        $display("FAIL rand_agg step %0d got cyc=%0d ret=%0d dec=%0d elig=%0d iss=%0d fin=%b want %0d %0d %0d %0d %0d %b",
                 i, cycles, instRetired, cyclesDecoded, cyclesEligible, cyclesIssued, finished,
                 m_cyc, m_ret, m_dec, m_elig, m_iss, m_fin);
      end
      checks++;
      if (n_cyc !== nsat(m_cyc) || n_ret !== nsat(m_ret) || n_finished !== m_fin) begin
        errors++;
        $display("FAIL rand_narrow step %0d got cyc=%0d ret=%0d fin=%b want %0d %0d %b",
                 i, n_cyc, n_ret, n_finished, nsat(m_cyc), nsat(m_ret), m_fin);
      end
      for (int w = 0; w < NW; w++) begin
        checks++;
        if (pw_dec[w*CW +: CW] !== 64'(m_pwdec[w]) || pw_waw[w*CW +: CW] !== 64'(m_waw[w]) ||
            pw_war[w*CW +: CW] !== 64'(m_war[w]) || pw_busy[w*CW +: CW] !== 64'(m_busy[w])) begin
          errors++;
          $display("FAIL rand_warp step %0d warp %0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i, w,
                   pw_dec[w*CW +: CW], pw_waw[w*CW +: CW], pw_war[w*CW +: CW], pw_busy[w*CW +: CW],
                   m_pwdec[w], m_waw[w], m_war[w], m_busy[w]);
        end
      end
    end
    idle_inputs(); reset_n = 1;
  endtask

  initial begin
    m_edge = 0; m_open = 0; m_end = -1; m_fin = 0;
    m_cyc = 0; m_ret = 0; m_dec = 0; m_elig = 0; m_iss = 0;
    for (int w = 0; w < NW; w++) begin m_pwdec[w] = 0; m_waw[w] = 0; m_war[w] = 0; m_busy[w] = 0; end
    reset_n = 0; idle_inputs();
    @(negedge clock);
    test_reset();
    test_basic_window();
    test_retire_decode();
    test_stall_priority();
    test_saturation();
    test_clear_precedence();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
